ring_mem_front: RTL
===================

# ring_mem_front

Parametrised ring-side front end for the DDR memory controller. It does the following:
- holds and releases the ring token;
- drains a resend queue onto the ring;
- nullifies consumed slots;
- captures Address slots and WriteData beats into a memory-op queue and a line-wide write-data queue;
- arbitrates round-robin among NUM_LOCAL local read requestors (display and similar) for memory-op queue slots.

It sits between the ring and the coherent memory-sequencing FSM, which consumes both queues and pushes into the resend queue.

## Interface
Parameters:
- WORDS_PER_LINE, 4: 32-bit WriteData beats per line; power of 2, ≥2. LINE_W = 32*WORDS_PER_LINE.
- MOPQ_DEPTH, 64: memory-op queue entries; power of 2.
- WDQ_DEPTH, 1024: write-data queue entries (lines); power of 2.
- RSQ_DEPTH, 64: resend queue entries; power of 2.
- WDQ_HEADROOM, 512: throttle the token while WDQ free entries < WDQ_HEADROOM.
- MAX_RESEND_BURST, 16: maximum resend slots emitted per token hold; ≥1.
- NUM_LOCAL, 1: local read requestors; 1..8.
- ADDR_W, 26: local request address width; ≤26.
- LOC_PREFIX, 6'b000100: bits [31:26] of local-request Address words.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- memEnable  in  1  token release permitted (low during DDR calibration/inhibit).
- RingIn  in  32  ring data.
- SlotTypeIn  in  4  slot type.
- SourceIn  in  4  slot source.
- RingOut / SlotTypeOut / SourceOut  out  32/4/4  ring outputs (combinational).
- locReq  in  NUM_LOCAL  local read request, held until acked.
- locAddr  in  NUM_LOCAL*ADDR_W  request addresses; requestor i at [i*ADDR_W +: ADDR_W].
- locAck  out  NUM_LOCAL  one-hot grant, one cycle.
- mopValid / mopReady / mopData  out/in/out  1/1/40  memory-op queue head {dest[39:36], type[35:32], data[31:0]}.
- wdValid / wdReady / wdData  out/in/out  1/1/LINE_W  write-data queue head; beat 0 in bits [31:0].
- rsValid / rsReady / rsData  in/out/in  1/1/40  resend push; rsReady = ~RSQ full.
- ovf  out  3  sticky overflow {rsq, wdq, mopq}.
- throttle  out  1  WDQ headroom violated.

## Operation
- Token FSM states: IDLE, DUMP, WAIT.
  - IDLE→DUMP when memEnable & ~throttle.
  - In DUMP:
    - each cycle with RSQ non-empty and burst count < MAX_RESEND_BURST, pop the RSQ head and drive it to the ring outputs (SourceOut = dest).
    - otherwise drive Token, data 0, source 0, clear the burst count and go to WAIT.
  - WAIT: on SlotTypeIn==Token, go to DUMP if memEnable & ~throttle, else IDLE.
- Outside DUMP-driven slots, an input slot is nullified (Null/0/0) if any of the following holds; otherwise it passes unchanged:
  - it is a Token;
  - SourceIn==0;
  - it is an Address with RingIn[31]=1.
- Ring capture is independent of FSM state:
  - An Address slot pushes {SourceIn, SlotTypeIn, RingIn} into MOPQ.
  - A WriteData slot stores RingIn into beat register [beatCnt]; beatCnt wraps modulo WORDS_PER_LINE.
  - The beat that completes a line schedules a WDQ push of the assembled line on the next cycle.
- Local arbitration:
  - A grant is possible only in a cycle with no ring Address slot and MOPQ not full.
  - The winner is the first requesting index at or after rrPtr; it receives locAck.
  - The winner's entry {4'b0, Address, LOC_PREFIX, zero-extended addr} is pushed to MOPQ.
  - rrPtr advances to winner+1 mod NUM_LOCAL.
- throttle = (WDQ_DEPTH − wdqCount) < WDQ_HEADROOM, where wdqCount includes the pending push.
- A push into a full queue is dropped and sets its ovf bit. ovf clears only on reset.

## Timing
- Ring outputs are combinational from the inputs and the FSM state.
- MOPQ push occurs at the clock edge of the Address slot; mopValid rises one cycle later.
- WDQ push occurs one cycle after the last beat; wdValid rises the cycle after that.
- Pop occurs on valid & ready at the clock edge.
- Simultaneous push and pop leaves the count unchanged. Pop of an empty queue is ignored.
- A ring Address always beats a local request; the requestor retries the next cycle.
- Reset, including mid-burst and mid-line, is asynchronous and causes:
  - state=IDLE;
  - beatCnt, rrPtr, burst count and all queue counts = 0;
  - ovf=0, locAck=0, mopValid=0, wdValid=0, rsReady=1, throttle=0 (WDQ_HEADROOM ≤ WDQ_DEPTH);
  - beat registers and partial lines are discarded.
- While reset is held, the ring outputs show pass-through/nullify behaviour.

## Structure
- Shared package holds:
  - slot-type constants (Token, Address, WriteData, Null);
  - the 40-bit queue entry field offsets;
  - the FSM state enum.
- One sub-module, ring_fifo: parametrised width/depth, synchronous, first-word-fall-through, with count/full/empty outputs and async reset. It is instantiated three times (MOPQ, WDQ, RSQ).

## Test plan
- Token handling (memEnable=1, RSQ holds 3 entries, MAX_RESEND_BURST=16):
  - the 3 entries appear on 3 consecutive cycles, followed by a Token;
  - FSM goes to WAIT; a Token in returns it to DUMP.
- Burst limit: MAX_RESEND_BURST=2 with 5 RSQ entries gives 2 entries then a Token. Remaining entries go out 2 per token hold.
- Write capture:
  - 4 WriteData beats 0x11,0x22,0x33,0x44 give wdData = 0x00000044_00000033_00000022_00000011;
  - the same test passes with WORDS_PER_LINE=8.
- Arbitration (NUM_LOCAL=3, all requesting):
  - acks are 0,1,2,0;
  - an Address slot in the ack-1 cycle delays ack 1 by one cycle;
  - the MOPQ entry data equals {6'b000100, addr}.
- Throttle (WDQ_DEPTH=8, WDQ_HEADROOM=4, wdReady=0):
  - after 5 lines, throttle=1 and the FSM parks in IDLE after the next Token;
  - draining 2 lines re-releases the token.
- Overflow and reset:
  - 65 Addresses with mopReady=0 set ovf[0]=1 and drop the 65th;
  - asynchronous reset mid-line clears ovf and beatCnt, and the next 4 beats form a clean line.

Source files
------------

// File: rtl/ring_mem_front_pkg.sv
// Shared definitions for the ring-side memory front end: slot types,
// queue entry layout and token FSM states.
package ring_mem_front_pkg;

  localparam logic [3:0] SLOT_NULL  = 4'h0;
  localparam logic [3:0] SLOT_TOKEN = 4'h1;
  localparam logic [3:0] SLOT_ADDR  = 4'h2;
  localparam logic [3:0] SLOT_WDATA = 4'h3;

  // 40-bit queue entry: {dest, type, data}
  localparam int ENT_W        = 40;
  localparam int ENT_DATA_LSB = 0;
  localparam int ENT_TYPE_LSB = 32;
  localparam int ENT_DEST_LSB = 36;

  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  slotType;
    logic [31:0] data;
  } memEnt_t;

  typedef enum logic [1:0] {ST_IDLE, ST_DUMP, ST_WAIT} tokState_t;

endpackage

// File: rtl/ring_mem_front_fifo.sv
// Synchronous first-word-fall-through FIFO; pushes into a full FIFO and
// pops from an empty FIFO are ignored.
module ring_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             pushData,
  input  logic                     pop,
  output logic [W-1:0]             popData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic          doPush, doPop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign popData = mem[rdPtr];

  always_ff @(posedge clock)
    if (doPush) mem[wrPtr] <= pushData;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      if (doPush && !doPop)      count <= count + (AW+1)'(1);
      else if (doPop && !doPush) count <= count - (AW+1)'(1);
    end

endmodule

// File: rtl/ring_mem_front.sv
// Ring-side front end of the DDR controller: token handling, resend drain,
// slot capture into memory-op / write-data queues and local read arbitration.
module ring_mem_front
  import ring_mem_front_pkg::*;
#(
  parameter int         WORDS_PER_LINE   = 4,
  parameter int         MOPQ_DEPTH       = 64,
  parameter int         WDQ_DEPTH        = 1024,
  parameter int         RSQ_DEPTH        = 64,
  parameter int         WDQ_HEADROOM     = 512,
  parameter int         MAX_RESEND_BURST = 16,
  parameter int         NUM_LOCAL        = 1,
  parameter int         ADDR_W           = 26,
  parameter logic [5:0] LOC_PREFIX       = 6'b000100,
  localparam int        LINE_W           = 32*WORDS_PER_LINE
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        memEnable,
  input  logic [31:0]                 RingIn,
  input  logic [3:0]                  SlotTypeIn,
  input  logic [3:0]                  SourceIn,
  output logic [31:0]                 RingOut,
  output logic [3:0]                  SlotTypeOut,
  output logic [3:0]                  SourceOut,
  input  logic [NUM_LOCAL-1:0]        locReq,
  input  logic [NUM_LOCAL*ADDR_W-1:0] locAddr,
  output logic [NUM_LOCAL-1:0]        locAck,
  output logic                        mopValid,
  input  logic                        mopReady,
  output logic [ENT_W-1:0]            mopData,
  output logic                        wdValid,
  input  logic                        wdReady,
  output logic [LINE_W-1:0]           wdData,
  input  logic                        rsValid,
  output logic                        rsReady,
  input  logic [ENT_W-1:0]            rsData,
  output logic [2:0]                  ovf,
  output logic                        throttle
);
  localparam int BCW = $clog2(WORDS_PER_LINE);
  localparam int BUW = $clog2(MAX_RESEND_BURST + 1);
  localparam int PW  = (NUM_LOCAL > 1) ? $clog2(NUM_LOCAL) : 1;
  localparam int WCW = $clog2(WDQ_DEPTH) + 1;

  tokState_t state, stateNxt;
  logic [BUW-1:0] burstCnt;
  logic           burstClr, rsPop, nullify;

  logic [BCW-1:0]                       beatCnt;
  logic [WORDS_PER_LINE-1:0][31:0]      beats;
  logic                                 wdPend;

  logic [PW-1:0]                        rrPtr, grantIdx, idx;
  logic                                 grantAny, grantOk;
  logic [NUM_LOCAL-1:0][ADDR_W-1:0]     locAddrArr;

  logic           ringAddr, ringWd;
  memEnt_t        mopPushData;
  logic           mopPush, mopFull, mopEmpty;
  logic           wdFull, wdEmpty;
  logic           rsFull, rsEmpty;
  logic [ENT_W-1:0] rsHead;
  logic [WCW-1:0]   wdCount;
  logic [WCW:0]     wdqOcc;
  logic [$clog2(MOPQ_DEPTH):0] unusedMopCount;
  logic [$clog2(RSQ_DEPTH):0]  unusedRsCount;

  assign ringAddr   = SlotTypeIn == SLOT_ADDR;
  assign ringWd     = SlotTypeIn == SLOT_WDATA;
  assign locAddrArr = locAddr;
  assign rsReady    = ~rsFull;
  assign mopValid   = ~mopEmpty;
  assign wdValid    = ~wdEmpty;

  // occupancy counts the line that is assembled but not yet pushed
  assign wdqOcc   = (WCW+1)'(wdCount) + (WCW+1)'(wdPend);
  assign throttle = (WDQ_DEPTH - int'(wdqOcc)) < WDQ_HEADROOM;

  // token FSM and ring output mux
  always_comb begin
    stateNxt    = state;
    rsPop       = 1'b0;
    burstClr    = 1'b0;
    nullify     = (SlotTypeIn == SLOT_TOKEN) || (SourceIn == 4'h0) ||
                  (ringAddr && RingIn[31]);
    RingOut     = nullify ? 32'h0 : RingIn;
    SlotTypeOut = nullify ? SLOT_NULL : SlotTypeIn;
    SourceOut   = nullify ? 4'h0 : SourceIn;
    unique case (state)
      ST_IDLE: if (memEnable && !throttle) stateNxt = ST_DUMP;
      ST_DUMP: begin
        if (!rsEmpty && burstCnt < BUW'(MAX_RESEND_BURST)) begin
          rsPop       = 1'b1;
          RingOut     = rsHead[ENT_DATA_LSB +: 32];
          SlotTypeOut = rsHead[ENT_TYPE_LSB +: 4];
          SourceOut   = rsHead[ENT_DEST_LSB +: 4];
        end else begin
          RingOut     = 32'h0;
          SlotTypeOut = SLOT_TOKEN;
          SourceOut   = 4'h0;
          burstClr    = 1'b1;
          stateNxt    = ST_WAIT;
        end
      end
      ST_WAIT:
        if (SlotTypeIn == SLOT_TOKEN)
          stateNxt = (memEnable && !throttle) ? ST_DUMP : ST_IDLE;
      default: stateNxt = ST_IDLE;
    endcase
  end

  // round-robin search starting at rrPtr
  always_comb begin
    grantAny = 1'b0;
    grantIdx = '0;
    idx      = '0;
    for (int k = 0; k < NUM_LOCAL; k++) begin
      idx = PW'((int'(rrPtr) + k) % NUM_LOCAL);
      if (!grantAny && locReq[idx]) begin
        grantAny = 1'b1;
        grantIdx = idx;
      end
    end
  end

  // ring Address slots always win the MOPQ write port
  assign grantOk = grantAny & ~ringAddr & ~mopFull & ~reset;
  assign locAck  = grantOk ? (NUM_LOCAL'(1) << grantIdx) : '0;
  assign mopPush = ringAddr | grantOk;

  always_comb begin
    mopPushData.dest     = SourceIn;
    mopPushData.slotType = SlotTypeIn;
    mopPushData.data     = RingIn;
    if (!ringAddr) begin
      mopPushData.dest     = 4'h0;
      mopPushData.slotType = SLOT_ADDR;
      mopPushData.data     = {LOC_PREFIX, 26'(locAddrArr[grantIdx])};
    end
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= ST_IDLE;
      burstCnt <= '0;
      beatCnt  <= '0;
      wdPend   <= 1'b0;
      rrPtr    <= '0;
      ovf      <= '0;
    end else begin
      state <= stateNxt;
      if (burstClr)   burstCnt <= '0;
      else if (rsPop) burstCnt <= burstCnt + BUW'(1);
      wdPend <= ringWd && (beatCnt == BCW'(WORDS_PER_LINE - 1));
      if (ringWd)  beatCnt <= beatCnt + BCW'(1);
      if (grantOk) rrPtr   <= PW'((int'(grantIdx) + 1) % NUM_LOCAL);
      ovf <= ovf | {rsValid & rsFull, wdPend & wdFull, mopPush & mopFull};
    end

  always_ff @(posedge clock or posedge reset)
    if (reset)       beats          <= '0;
    else if (ringWd) beats[beatCnt] <= RingIn;

  ring_fifo #(.W(ENT_W), .DEPTH(MOPQ_DEPTH)) uMopq (
    .clock(clock), .reset(reset),
    .push(mopPush), .pushData(mopPushData),
    .pop(mopReady), .popData(mopData),
    .count(unusedMopCount), .full(mopFull), .empty(mopEmpty)
  );

  ring_fifo #(.W(LINE_W), .DEPTH(WDQ_DEPTH)) uWdq (
    .clock(clock), .reset(reset),
    .push(wdPend), .pushData(beats),
    .pop(wdReady), .popData(wdData),
    .count(wdCount), .full(wdFull), .empty(wdEmpty)
  );

  ring_fifo #(.W(ENT_W), .DEPTH(RSQ_DEPTH)) uRsq (
    .clock(clock), .reset(reset),
    .push(rsValid), .pushData(rsData),
    .pop(rsPop), .popData(rsHead),
    .count(unusedRsCount), .full(rsFull), .empty(rsEmpty)
  );

endmodule
